// File: rtl/alpha_fwd_recursion.sv
// alpha_fwd_recursion: Max-log-MAP forward (alpha) recursion over the
// 8-state trellis.
// Each accepted gamma vector produces one registered 8-state alpha vector.
// Frames are FRAME_LEN steps long and run under a start/done handshake.
// Build option: define ALPHA_NORM_EN to subtract the new a0 from every alpha
// on each step, so that a0 reads 0. Otherwise alphas accumulate raw and
// saturate.
// Assumes ALPHA_W >= 16, so that a gamma value fits the extended sum width.
module alpha_fwd_recursion #(
    parameter int FRAME_LEN = 8,
    parameter int ALPHA_W   = 18,
    parameter int STEP_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      gamma_valid,
    input  logic signed [15:0]        g00,
    input  logic signed [15:0]        g01,
    input  logic signed [15:0]        g10,
    input  logic signed [15:0]        g11,
    input  logic signed [15:0]        g20,
    input  logic signed [15:0]        g21,
    input  logic signed [15:0]        g30,
    input  logic signed [15:0]        g31,
    input  logic signed [15:0]        g40,
    input  logic signed [15:0]        g41,
    input  logic signed [15:0]        g50,
    input  logic signed [15:0]        g51,
    input  logic signed [15:0]        g60,
    input  logic signed [15:0]        g61,
    input  logic signed [15:0]        g70,
    input  logic signed [15:0]        g71,
    output logic                      gamma_ready,
    output logic signed [ALPHA_W-1:0] a0,
    output logic signed [ALPHA_W-1:0] a1,
    output logic signed [ALPHA_W-1:0] a2,
    output logic signed [ALPHA_W-1:0] a3,
    output logic signed [ALPHA_W-1:0] a4,
    output logic signed [ALPHA_W-1:0] a5,
    output logic signed [ALPHA_W-1:0] a6,
    output logic signed [ALPHA_W-1:0] a7,
    output logic                      alpha_valid,
    output logic [STEP_W-1:0]         step_idx,
    output logic                      busy,
    output logic                      done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Clamp limits in the extended (ALPHA_W+1) sum domain.
    localparam logic signed [ALPHA_W:0] SUM_MAX = {2'b00, {(ALPHA_W-1){1'b1}}};
    localparam logic signed [ALPHA_W:0] SUM_MIN = {2'b11, {(ALPHA_W-1){1'b0}}};
    // NEG_INF = -2^(ALPHA_W-2) leaves headroom below it before the clamp.
    localparam logic signed [ALPHA_W-1:0] NEG_INF = {2'b11, {(ALPHA_W-2){1'b0}}};
    localparam logic signed [ALPHA_W-1:0] ZERO    = {ALPHA_W{1'b0}};
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(FRAME_LEN - 1);
    localparam logic [STEP_W-1:0] STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};

    function automatic logic signed [ALPHA_W:0] ext_alpha(input logic signed [ALPHA_W-1:0] a);
        return {a[ALPHA_W-1], a};
    endfunction

    function automatic logic signed [ALPHA_W:0] ext_gamma(input logic signed [15:0] g);
        return {{(ALPHA_W-15){g[15]}}, g};
    endfunction

    function automatic logic signed [ALPHA_W-1:0] sat(input logic signed [ALPHA_W:0] v);
        if (v > SUM_MAX) begin
            return SUM_MAX[ALPHA_W-1:0];
        end else if (v < SUM_MIN) begin
            return SUM_MIN[ALPHA_W-1:0];
        end else begin
            return v[ALPHA_W-1:0];
        end
    endfunction

    logic [0:0]                state_r;
    logic                      busy_r;
    logic                      alpha_valid_r;
    logic                      done_r;
    logic [STEP_W-1:0]         step_r;
    logic signed [ALPHA_W-1:0] alpha_r      [8];

    logic signed [15:0]        gam_s        [8][2];
    logic signed [ALPHA_W:0]   sum0_s       [8];
    logic signed [ALPHA_W:0]   sum1_s       [8];
    logic signed [ALPHA_W:0]   max_s        [8];
    logic signed [ALPHA_W-1:0] sat_s        [8];
    logic signed [ALPHA_W-1:0] next_alpha_s [8];
    logic                      accept_s;
    logic                      last_s;

    assign gam_s[0][0] = g00;
    assign gam_s[0][1] = g01;
    assign gam_s[1][0] = g10;
    assign gam_s[1][1] = g11;
    assign gam_s[2][0] = g20;
    assign gam_s[2][1] = g21;
    assign gam_s[3][0] = g30;
    assign gam_s[3][1] = g31;
    assign gam_s[4][0] = g40;
    assign gam_s[4][1] = g41;
    assign gam_s[5][0] = g50;
    assign gam_s[5][1] = g51;
    assign gam_s[6][0] = g60;
    assign gam_s[6][1] = g61;
    assign gam_s[7][0] = g70;
    assign gam_s[7][1] = g71;

    // Add-compare-select per target state s'. The predecessors are
    // {0,s'[2:1]} and {1,s'[2:1]}.
    // The input bit is u = s'[0] ^ f(pred), where f(pred) = pred[2] ^ pred[1] = B ^ s'[2].
    for (genvar sp = 0; sp < 8; sp++) begin : g_acs
        localparam int P0 = sp / 2;
        localparam int P1 = 4 + sp / 2;
        localparam int U0 = (sp % 2) ^ ((sp / 4) % 2);
        localparam int U1 = 1 - U0;

        assign sum0_s[sp] = ext_alpha(alpha_r[P0]) + ext_gamma(gam_s[P0][U0]);
        assign sum1_s[sp] = ext_alpha(alpha_r[P1]) + ext_gamma(gam_s[P1][U1]);
        // Strictly-greater test: on a tie, the s[2]=0 predecessor is kept.
        assign max_s[sp]  = (sum1_s[sp] > sum0_s[sp]) ? sum1_s[sp] : sum0_s[sp];
        assign sat_s[sp]  = sat(max_s[sp]);
`ifdef ALPHA_NORM_EN
        assign next_alpha_s[sp] = sat(ext_alpha(sat_s[sp]) - ext_alpha(sat_s[0]));
`else
        assign next_alpha_s[sp] = sat_s[sp];
`endif
    end

    assign accept_s = (state_r == RUN) && gamma_valid;
    assign last_s   = (step_r == LAST_STEP);

    // Frame FSM, alpha registers and the handshake/status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            busy_r        <= 1'b0;
            alpha_valid_r <= 1'b0;
            done_r        <= 1'b0;
            step_r        <= {STEP_W{1'b0}};
            for (int i = 0; i < 8; i++) begin
                alpha_r[i] <= (i == 0) ? ZERO : NEG_INF;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    alpha_valid_r <= 1'b0;
                    done_r        <= 1'b0;
                    if (start) begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        step_r  <= {STEP_W{1'b0}};
                        for (int i = 0; i < 8; i++) begin
                            alpha_r[i] <= (i == 0) ? ZERO : NEG_INF;
                        end
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept_s) begin
                        for (int i = 0; i < 8; i++) begin
                            alpha_r[i] <= next_alpha_s[i];
                        end
                        alpha_valid_r <= 1'b1;
                        step_r        <= step_r + STEP_ONE;
                        if (last_s) begin
                            done_r  <= 1'b1;
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            done_r  <= 1'b0;
                        end
                    end else begin
                        alpha_valid_r <= 1'b0;
                        done_r        <= 1'b0;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    busy_r        <= 1'b0;
                    alpha_valid_r <= 1'b0;
                    done_r        <= 1'b0;
                end
            endcase
        end
    end

    assign gamma_ready = busy_r;
    assign busy        = busy_r;
    assign alpha_valid = alpha_valid_r;
    assign done        = done_r;
    assign step_idx    = step_r;
    assign a0 = alpha_r[0];
    assign a1 = alpha_r[1];
    assign a2 = alpha_r[2];
    assign a3 = alpha_r[3];
    assign a4 = alpha_r[4];
    assign a5 = alpha_r[5];
    assign a6 = alpha_r[6];
    assign a7 = alpha_r[7];

endmodule

// File: tb/tb_alpha_fwd_recursion.sv
// Self-checking bench for alpha_fwd_recursion.
// The reference model walks the trellis forward from each state and input
// bit, and keeps the best candidate metric for every successor state.
// Honours ALPHA_NORM_EN in the same way as the design.
module tb_alpha_fwd_recursion;

    localparam int FL = 8;
    localparam int AW = 18;
    localparam int SW = 8;
    localparam longint NEG_INF = -(longint'(1) <<< (AW - 2));
    localparam longint A_MAX   = (longint'(1) <<< (AW - 1)) - 1;
    localparam longint A_MIN   = -(longint'(1) <<< (AW - 1));

    logic clk, rst, start, gamma_valid;
    logic signed [15:0]   g_tb  [8][2];
    logic                 gamma_ready, alpha_valid, busy, done;
    logic signed [AW-1:0] a_out [8];
    logic [SW-1:0]        step_idx;

    int n_vec = 0;
    int n_err = 0;

    alpha_fwd_recursion #(.FRAME_LEN(FL), .ALPHA_W(AW), .STEP_W(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .gamma_valid(gamma_valid),
        .g00(g_tb[0][0]), .g01(g_tb[0][1]), .g10(g_tb[1][0]), .g11(g_tb[1][1]),
        .g20(g_tb[2][0]), .g21(g_tb[2][1]), .g30(g_tb[3][0]), .g31(g_tb[3][1]),
        .g40(g_tb[4][0]), .g41(g_tb[4][1]), .g50(g_tb[5][0]), .g51(g_tb[5][1]),
        .g60(g_tb[6][0]), .g61(g_tb[6][1]), .g70(g_tb[7][0]), .g71(g_tb[7][1]),
        .gamma_ready(gamma_ready),
        .a0(a_out[0]), .a1(a_out[1]), .a2(a_out[2]), .a3(a_out[3]),
        .a4(a_out[4]), .a5(a_out[5]), .a6(a_out[6]), .a7(a_out[7]),
        .alpha_valid(alpha_valid), .step_idx(step_idx), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint clampv(input longint v);
        if (v > A_MAX) return A_MAX;
        if (v < A_MIN) return A_MIN;
        return v;
    endfunction

    // ---------------- reference model ----------------
    longint m_alpha [8];
    longint m_nx    [8];
    bit     m_run, m_valid, m_done;
    int     m_step;

    // Forward trellis walk: every (state, bit) pair offers a candidate to its successor state.
    always_comb begin
        int ns;
        longint c;
        longint base;
        ns = 0;
        c = 0;
        base = 0;
        for (int i = 0; i < 8; i++) m_nx[i] = -(longint'(1) <<< 40);
        for (int s = 0; s < 8; s++) begin
            for (int u = 0; u < 2; u++) begin
                ns = ((s & 3) << 1) | (u ^ (((s >> 2) ^ (s >> 1)) & 1));
                c  = m_alpha[s] + longint'(g_tb[s][u]);
                if (c > m_nx[ns]) m_nx[ns] = c;
            end
        end
        for (int i = 0; i < 8; i++) m_nx[i] = clampv(m_nx[i]);
`ifdef ALPHA_NORM_EN
        base = m_nx[0];
        for (int i = 0; i < 8; i++) m_nx[i] = clampv(m_nx[i] - base);
`endif
    end

    // Expected frame-level behaviour, advanced on each clock edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run <= 1'b0; m_valid <= 1'b0; m_done <= 1'b0; m_step <= 0;
            for (int i = 0; i < 8; i++) m_alpha[i] <= (i == 0) ? 64'sd0 : NEG_INF;
        end else if (!m_run) begin
            m_valid <= 1'b0; m_done <= 1'b0;
            if (start) begin
                m_run <= 1'b1; m_step <= 0;
                for (int i = 0; i < 8; i++) m_alpha[i] <= (i == 0) ? 64'sd0 : NEG_INF;
            end
        end else if (gamma_valid) begin
            for (int i = 0; i < 8; i++) m_alpha[i] <= m_nx[i];
            m_valid <= 1'b1;
            m_step  <= m_step + 1;
            m_done  <= (m_step + 1 == FL);
            if (m_step + 1 == FL) m_run <= 1'b0;
        end else begin
            m_valid <= 1'b0; m_done <= 1'b0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("busy", busy, m_run);
        chk("gamma_ready", gamma_ready, m_run);
        chk("alpha_valid", alpha_valid, m_valid);
        chk("done", done, m_done);
        chk("step_idx", step_idx, m_step);
        for (int i = 0; i < 8; i++) chk("alpha", a_out[i], m_alpha[i]);
    end

    // ---------------- stimulus ----------------
    logic signed [15:0] st   [FL][8][2];
    longint             s2_final [8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_gammas;
        for (int s = 0; s < 8; s++)
            for (int u = 0; u < 2; u++)
                g_tb[s][u] = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                         : 16'($urandom_range(0, 400) - 200);
    endtask

    task automatic sc1;
        int lit0 [8] = '{5, 4, 1, 10, 15, 3, 2, 2};
        int lit1 [8] = '{6, 11, 7, 9, 13, 17, 14, 6};
        longint e0, e1;
`ifdef ALPHA_NORM_EN
        e0 = 0; e1 = 1;
`else
        e0 = 5; e1 = 6;
`endif
        start = 1'b1; gamma_valid = 1'b0; tick; start = 1'b0;
        for (int s = 0; s < 8; s++) begin
            g_tb[s][0] = 16'(lit0[s]);
            g_tb[s][1] = 16'(lit1[s]);
        end
        gamma_valid = 1'b1; tick; gamma_valid = 1'b0;
        chk("s1_valid", alpha_valid, 1);
        chk("s1_step", step_idx, 1);
        chk("s1_a0", a_out[0], e0);
        chk("s1_a1", a_out[1], e1);
        chk("s1_model_a0", m_alpha[0], e0);
        chk("s1_model_a1", m_alpha[1], e1);
        for (int i = 2; i < 8; i++) chk("s1_a_low", (longint'(a_out[i]) <= NEG_INF + 17) ? 1 : 0, 1);
        for (int k = 1; k < FL; k++) begin
            rand_gammas; gamma_valid = 1'b1; tick;
        end
        gamma_valid = 1'b0;
        chk("s1_done", done, 1);
        tick;
    endtask

    // mode 0: gamma every cycle, 1: pattern 1,0,0, 2: random.
    task automatic run_frame(input int mode, input bit store, input bit replay, input bit inj);
        int  steps = 0;
        int  cyc = 0;
        bit  got_done = 1'b0;
        bit  gv;
        start = 1'b1;
        gamma_valid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        rand_gammas;
        tick;
        start = 1'b0;
        while (!got_done && cyc < 100) begin
            gv = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            if (replay) begin
                g_tb = st[steps];
            end else begin
                rand_gammas;
            end
            if (store && gv) st[steps] = g_tb;
            start = (inj && cyc == 3) ? 1'b1 : 1'b0;
            gamma_valid = gv;
            tick;
            if (done) got_done = 1'b1;
            if (gv) steps++;
            cyc++;
        end
        gamma_valid = 1'b0; start = 1'b0;
        chk("frame_done", got_done, 1);
        chk("frame_steps", steps, FL);
    endtask

    initial begin
        longint s4 [8] = '{32767, 65534, 98301, 131068, 131071, 131071, 131071, 131071};
        rst = 1'b1; start = 1'b0; gamma_valid = 1'b0;
        for (int s = 0; s < 8; s++) begin
            g_tb[s][0] = 16'sd0;
            g_tb[s][1] = 16'sd0;
        end
        tick; tick;
        chk("rst_a0", a_out[0], 0);
        chk("rst_a7", a_out[7], NEG_INF);
        chk("rst_busy", busy, 0);
        rst = 1'b0; tick;

        // Scenario 1: the single hand-worked step.
        sc1;

        // Scenarios 2 and 3: a back-to-back frame, then a replay of it with gaps.
        run_frame(0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) s2_final[i] = m_alpha[i];
        tick;
        run_frame(1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) chk("s3_final", a_out[i], s2_final[i]);
        tick;

        // Scenario 4: maximum gammas drive a0 into positive saturation.
        start = 1'b1; tick; start = 1'b0;
        for (int s = 0; s < 8; s++) begin
            g_tb[s][0] = 16'sd32767;
            g_tb[s][1] = 16'sd32767;
        end
        for (int k = 0; k < FL; k++) begin
            gamma_valid = 1'b1; tick;
`ifdef ALPHA_NORM_EN
            chk("s4_a0", a_out[0], 0);
`else
            chk("s4_a0", a_out[0], s4[k]);
`endif
        end
        gamma_valid = 1'b0; tick;

        // Scenario 5: reset in the middle of a frame, then a fresh frame.
        start = 1'b1; tick; start = 1'b0;
        rand_gammas; gamma_valid = 1'b1; tick; tick;
        #2 rst = 1'b1;
        #1;
        chk("s5_a0", a_out[0], 0);
        chk("s5_a1", a_out[1], NEG_INF);
        chk("s5_valid", alpha_valid, 0);
        chk("s5_busy", busy, 0);
        chk("s5_step", step_idx, 0);
        chk("s5_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0; gamma_valid = 1'b0;
        tick;
        sc1;

        // Scenario 6: start during RUN is ignored; gamma_valid in IDLE does nothing.
        run_frame(0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            rand_gammas; gamma_valid = 1'b1; tick;
            chk("s6_idle_valid", alpha_valid, 0);
        end
        gamma_valid = 1'b0; tick;

        // Random frames with random stalls.
        for (int f = 0; f < 20; f++) begin
            run_frame(2, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) tick;
        end
        tick; tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
